conv_window_sequencer: RTL and testbench

Sequences one KERNEL_SIZE x KERNEL_SIZE convolution window through the shared floating-point multiply-accumulate datapath.
- Accepts a packed filter/image window via a valid/ready handshake and latches it.
- Issues the element pairs one per accepted cycle to the MAC, in index order 0..N-1.
- Waits for the MAC's accumulated result and presents it on an output handshake.
- Replaces free-running pulse-driven element stepping with a deterministic, back-pressured schedule.

---
 rtl/conv_window_sequencer_pkg.sv | 21 ++
 rtl/conv_window_sequencer_element_mux.sv | 33 +++
 rtl/conv_window_sequencer.sv | 139 +++++++++++++
 tb/tb_conv_window_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_sequencer_pkg.sv
// Shared definitions for the convolution window sequencer family.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package conv_window_sequencer_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // IEEE-754 single-precision constants
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    // Number of elements in a square window of side k
    function automatic int unsigned num_elems(input int unsigned k);
        return k * k;
    endfunction

endpackage

// File: rtl/conv_window_sequencer_element_mux.sv
// Combinational pick of element idx from packed filter/image window registers.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller owns idx and its stepping.
//
// Ports:
//   i_filter / i_image : packed windows, element i at [DATA_WIDTH*i +: DATA_WIDTH]
//   i_idx              : element index, 0..N-1
//   o_a / o_b          : selected filter / image element (zero if idx is out of range)
module conv_element_mux
    import conv_window_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 9,
    parameter int IDX_W      = (N > 1) ? $clog2(N) : 1
)(
    input  logic [N*DATA_WIDTH-1:0] i_filter,
    input  logic [N*DATA_WIDTH-1:0] i_image,
    input  logic [IDX_W-1:0]        i_idx,
    output logic [DATA_WIDTH-1:0]   o_a,
    output logic [DATA_WIDTH-1:0]   o_b
);

    always_comb begin
        o_a = '0;
        o_b = '0;
        // Guard keeps non-power-of-two N from selecting past the window
        if (int'(i_idx) < N) begin
            o_a = i_filter[DATA_WIDTH*int'(i_idx) +: DATA_WIDTH];
            o_b = i_image [DATA_WIDTH*int'(i_idx) +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Steps one KERNEL_SIZE^2 window through the shared FP MAC and returns its result.
// Latency: 1 accept + N issue + MAC latency + 1 register cycle to out_valid (op_ready high).
// Backpressure: op_ready stalls issue with operands held; out_ready holds DONE; win_ready only in IDLE.
//
// Ports:
//   i_clk, i_reset (async, active low)
//   window in : i_win_valid / o_win_ready, i_filter, i_image
//   MAC issue : o_op_valid / i_op_ready, o_op_a, o_op_b, o_op_first, o_op_last
//   MAC result: i_mac_res_valid (pulse), i_mac_res
//   result out: o_out_valid / i_out_ready, o_out_data, o_out_err (timeout), o_busy
module conv_window_sequencer
    import conv_window_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int KERNEL_SIZE    = 3,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic                                            i_clk,
    input  logic                                            i_reset,
    input  logic                                            i_win_valid,
    output logic                                            o_win_ready,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   i_filter,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   i_image,
    output logic                                            o_op_valid,
    input  logic                                            i_op_ready,
    output logic [DATA_WIDTH-1:0]                           o_op_a,
    output logic [DATA_WIDTH-1:0]                           o_op_b,
    output logic                                            o_op_first,
    output logic                                            o_op_last,
    input  logic                                            i_mac_res_valid,
    input  logic [DATA_WIDTH-1:0]                           i_mac_res,
    output logic                                            o_out_valid,
    input  logic                                            i_out_ready,
    output logic [DATA_WIDTH-1:0]                           o_out_data,
    output logic                                            o_out_err,
    output logic                                            o_busy
);

    localparam int N      = int'(num_elems(KERNEL_SIZE));
    localparam int WIN_W  = N * DATA_WIDTH;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    // Timer counts 0..TIMEOUT_CYCLES-1, giving exactly TIMEOUT_CYCLES WAIT cycles
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [TMR_W-1:0]      r_timer;
    logic [WIN_W-1:0]      r_filter;
    logic [WIN_W-1:0]      r_image;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_err;

    logic [DATA_WIDTH-1:0] w_elem_a;
    logic [DATA_WIDTH-1:0] w_elem_b;
    logic                  w_issue;

    conv_element_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .IDX_W      (IDX_W)
    ) u_elem_mux (
        .i_filter   (r_filter),
        .i_image    (r_image),
        .i_idx      (r_idx),
        .o_a        (w_elem_a),
        .o_b        (w_elem_b)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_timer    <= '0;
            r_filter   <= '0;
            r_image    <= '0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_win_valid) begin
                        r_filter <= i_filter;
                        r_image  <= i_image;
                        r_idx    <= '0;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Without op_ready nothing moves, so the MAC sees stable operands
                    if (i_op_ready) begin
                        if (r_idx == IDX_LAST) begin
                            r_timer <= '0;
                            r_state <= ST_WAIT;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    // A real result beats the timeout when both land on the same cycle
                    if (i_mac_res_valid) begin
                        r_out_data <= i_mac_res;
                        r_out_err  <= 1'b0;
                        r_state    <= ST_DONE;
                    end else if (r_timer >= TMR_LAST) begin
                        r_out_data <= '0;
                        r_out_err  <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_issue     = (r_state == ST_ISSUE);
    assign o_win_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_op_valid  = w_issue;
    // Operand bus reads zero outside ISSUE so idle/wait cycles show no stale element
    assign o_op_a      = w_issue ? w_elem_a : '0;
    assign o_op_b      = w_issue ? w_elem_b : '0;
    assign o_op_first  = w_issue && (r_idx == '0);
    assign o_op_last   = w_issue && (r_idx == IDX_LAST);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_out_data  = r_out_data;
    assign o_out_err   = r_out_err;

endmodule

// File: tb/tb_conv_window_sequencer.sv
module tb_conv_window_sequencer;

    localparam int DW = 32;
    localparam int N  = 9;
    localparam int WW = N * DW;
    localparam int TO = 255;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        first;
        logic        last;
    } op_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } res_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          win_valid;
    logic [WW-1:0] filter;
    logic [WW-1:0] image;
    logic          op_ready;
    logic          out_ready;
    logic          mac_pulse = 1'b0;
    logic [31:0]   mac_val;
    logic          stray_vld;
    logic [31:0]   stray_val;
    logic          mac_res_valid;
    logic [31:0]   mac_res;

    logic          o_win_ready, o_op_valid, o_op_first, o_op_last;
    logic [31:0]   o_op_a, o_op_b, o_out_data;
    logic          o_out_valid, o_out_err, o_busy;

    op_t  exp_op[$];
    res_t exp_res[$];
    op_t  mon_op;
    res_t mon_res;

    int total = 0;
    int bad   = 0;
    int mac_delay = -1;
    int mac_cnt   = 0;

    logic [31:0]   fv [N];
    logic [31:0]   iv [N];
    logic [WW-1:0] f_tab, i_tab, f_one, i_two;

    always #5 clk = ~clk;

    assign mac_res_valid = mac_pulse | stray_vld;
    assign mac_res       = mac_pulse ? mac_val : stray_val;

    conv_window_sequencer #(
        .DATA_WIDTH     (DW),
        .KERNEL_SIZE    (3),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_win_valid     (win_valid),
        .o_win_ready     (o_win_ready),
        .i_filter        (filter),
        .i_image         (image),
        .o_op_valid      (o_op_valid),
        .i_op_ready      (op_ready),
        .o_op_a          (o_op_a),
        .o_op_b          (o_op_b),
        .o_op_first      (o_op_first),
        .o_op_last       (o_op_last),
        .i_mac_res_valid (mac_res_valid),
        .i_mac_res       (mac_res),
        .o_out_valid     (o_out_valid),
        .i_out_ready     (out_ready),
        .o_out_data      (o_out_data),
        .o_out_err       (o_out_err),
        .o_busy          (o_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // MAC model: after the last pair, pulses the result mac_delay+1 cycles later
    initial begin
        forever begin
            @(negedge clk);
            mac_pulse = 1'b0;
            if (mac_cnt > 0) begin
                mac_cnt--;
                if (mac_cnt == 0) mac_pulse = 1'b1;
            end
            if (reset && o_op_valid && op_ready && o_op_last && mac_delay >= 0)
                mac_cnt = mac_delay + 1;
        end
    end

    // Scoreboard monitor: compares every accepted pair and every delivered result
    initial begin
        forever begin
            @(negedge clk);
            if (reset && o_op_valid && op_ready) begin
                if (exp_op.size() == 0) begin
                    check("op_unexpected", 64'(o_op_valid), 64'(0));
                end else begin
                    mon_op = exp_op.pop_front();
                    check("op_a",     64'(o_op_a),     64'(mon_op.a));
                    check("op_b",     64'(o_op_b),     64'(mon_op.b));
                    check("op_first", 64'(o_op_first), 64'(mon_op.first));
                    check("op_last",  64'(o_op_last),  64'(mon_op.last));
                end
            end
            if (reset && o_out_valid && out_ready) begin
                if (exp_res.size() == 0) begin
                    check("res_unexpected", 64'(o_out_valid), 64'(0));
                end else begin
                    mon_res = exp_res.pop_front();
                    check("out_data", 64'(o_out_data), 64'(mon_res.data));
                    check("out_err",  64'(o_out_err),  64'(mon_res.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outs();
        check("rst_win_ready", 64'(o_win_ready), 64'(1));
        check("rst_op_valid",  64'(o_op_valid),  64'(0));
        check("rst_op_a",      64'(o_op_a),      64'(0));
        check("rst_op_b",      64'(o_op_b),      64'(0));
        check("rst_op_first",  64'(o_op_first),  64'(0));
        check("rst_op_last",   64'(o_op_last),   64'(0));
        check("rst_out_valid", 64'(o_out_valid), 64'(0));
        check("rst_out_data",  64'(o_out_data),  64'(0));
        check("rst_out_err",   64'(o_out_err),   64'(0));
        check("rst_busy",      64'(o_busy),      64'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes expectations, presents the window, returns 1ns after the accepting edge
    task automatic send_window(input logic [WW-1:0] f, input logic [WW-1:0] im,
                               input int d, input logic [31:0] v,
                               input logic [31:0] ed, input logic ee);
        op_t  e;
        res_t r;
        int   k;
        for (int i = 0; i < N; i++) begin
            e.a     = f[i*DW +: DW];
            e.b     = im[i*DW +: DW];
            e.first = (i == 0);
            e.last  = (i == N - 1);
            exp_op.push_back(e);
        end
        r.data = ed;
        r.err  = ee;
        exp_res.push_back(r);
        mac_delay = d;
        mac_val   = v;
        filter    = f;
        image     = im;
        k = 0;
        while (!o_win_ready && k < 100) begin
            tick();
            k++;
        end
        check("win_ready_wait", 64'(o_win_ready), 64'(1));
        win_valid = 1'b1;
        tick();
        win_valid = 1'b0;
        // Scrambled inputs prove the window was latched
        filter = '1;
        image  = '1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (o_busy && k < 1000) begin
            tick();
            k++;
        end
        check("idle_wait", 64'(o_busy), 64'(0));
    endtask

    initial begin
        int opcnt, first_c, last_c, lat, wcnt;
        logic found;

        fv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        for (int i = 0; i < N; i++) begin
            iv[i] = 32'hB000_0100 + 32'(i);
            f_tab[i*DW +: DW] = fv[i];
            i_tab[i*DW +: DW] = iv[i];
            f_one[i*DW +: DW] = 32'h3F800000;
            i_two[i*DW +: DW] = 32'h40000000;
        end

        reset = 1'b1; win_valid = 1'b0; op_ready = 1'b1; out_ready = 1'b1;
        stray_vld = 1'b0; stray_val = '0; mac_val = '0; filter = '0; image = '0;
        #1 reset = 1'b0;
        #1 check_reset_outs();
        tick(); tick();
        reset = 1'b1;
        tick();

        // Basic window: 9 x (1.0 * 2.0) = 18.0, MAC latency 2
        send_window(f_one, i_two, 2, 32'h41900000, 32'h41900000, 1'b0);
        opcnt = 0; first_c = -1; last_c = -1; lat = -1;
        for (int c = 1; c < 40; c++) begin
            if (o_op_valid) begin
                opcnt++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (o_out_valid) begin
                lat = c;
                break;
            end
            tick();
        end
        check("basic_op_cycles", 64'(opcnt), 64'(9));
        check("basic_first_op_cycle", 64'(first_c), 64'(1));
        check("basic_last_op_cycle", 64'(last_c), 64'(9));
        check("basic_latency", 64'(lat), 64'(13));
        wait_idle();

        // Stray MAC result while idle must be ignored
        stray_val = 32'h40400000; stray_vld = 1'b1;
        tick();
        stray_vld = 1'b0;
        tick();
        check("idle_stray_out_valid", 64'(o_out_valid), 64'(0));
        check("idle_stray_busy", 64'(o_busy), 64'(0));

        // Back-pressure: op_ready low for 3 cycles at idx 4
        send_window(f_tab, i_tab, 3, 32'h42340000, 32'h42340000, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_op_valid && o_op_a == fv[4]) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("bp_find_idx4", 64'(found), 64'(1));
        op_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("bp_hold_valid", 64'(o_op_valid), 64'(1));
            check("bp_hold_a", 64'(o_op_a), 64'(fv[4]));
            check("bp_hold_b", 64'(o_op_b), 64'(iv[4]));
            tick();
        end
        op_ready = 1'b1;
        wait_idle();

        // Timeout: MAC never answers
        send_window(f_one, i_two, -1, 32'h0, 32'h0, 1'b1);
        wcnt = 0;
        for (int k = 0; k < 400; k++) begin
            if (o_out_valid) break;
            if (o_busy && !o_op_valid) wcnt++;
            tick();
        end
        check("timeout_wait_cycles", 64'(wcnt), 64'(TO));
        check("timeout_out_err", 64'(o_out_err), 64'(1));
        wait_idle();

        // Output stall with stray result during DONE
        out_ready = 1'b0;
        send_window(f_tab, i_tab, 1, 32'h40800000, 32'h40800000, 1'b0);
        for (int k = 0; k < 40 && !o_out_valid; k++) tick();
        for (int j = 0; j < 5; j++) begin
            if (j == 1) begin
                stray_val = 32'h40400000;
                stray_vld = 1'b1;
            end
            if (j == 2) stray_vld = 1'b0;
            check("stall_out_valid", 64'(o_out_valid), 64'(1));
            check("stall_win_ready", 64'(o_win_ready), 64'(0));
            check("stall_out_data", 64'(o_out_data), 64'(32'h40800000));
            tick();
        end
        out_ready = 1'b1;
        check("handshake_win_ready", 64'(o_win_ready), 64'(0));
        tick();
        check("after_hs_win_ready", 64'(o_win_ready), 64'(1));
        check("after_hs_out_valid", 64'(o_out_valid), 64'(0));

        // Reset at idx 5 discards the window
        send_window(f_tab, i_tab, 2, 32'h11111111, 32'h11111111, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_op_valid && o_op_a == fv[5]) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("rst_find_idx5", 64'(found), 64'(1));
        #2 reset = 1'b0;
        #1 check_reset_outs();
        exp_op.delete();
        exp_res.delete();
        tick(); tick();
        reset = 1'b1;
        tick();
        send_window(f_tab, i_tab, 2, 32'h42340000, 32'h42340000, 1'b0);
        check("post_rst_first", 64'(o_op_first), 64'(1));
        check("post_rst_a0", 64'(o_op_a), 64'(fv[0]));
        wait_idle();

        // Result arriving on the exact timeout cycle wins
        send_window(f_one, i_two, TO - 1, 32'h41200000, 32'h41200000, 1'b0);
        wait_idle();

        tick();
        check("op_queue_drained", 64'(exp_op.size()), 64'(0));
        check("res_queue_drained", 64'(exp_res.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
